// File: rtl/dmem_responder_pkg.sv
// Shared CPU-side definitions for the data-memory responder: access-size
// encodings, responder FSM states and the size/alignment helpers used by the decoder.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    REQ_BYTE    = 2'b00,
    REQ_HALF    = 2'b01,
    REQ_WORD    = 2'b10,
    REQ_ILLEGAL = 2'b11
  } req_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam int unsigned SIZE_BYTE_BYTES = 1;
  localparam int unsigned SIZE_HALF_BYTES = 2;
  localparam int unsigned SIZE_WORD_BYTES = 4;

  function automatic int unsigned access_bytes(req_type_e t);
    case (t)
      REQ_BYTE: return SIZE_BYTE_BYTES;
      REQ_HALF: return SIZE_HALF_BYTES;
      REQ_WORD: return SIZE_WORD_BYTES;
      default:  return 0;
    endcase
  endfunction

  // The illegal encoding is reported through the same error path as misalignment.
  function automatic logic access_error(req_type_e t, logic [1:0] byte_off);
    case (t)
      REQ_BYTE: return 1'b0;
      REQ_HALF: return byte_off[0];
      REQ_WORD: return byte_off != 2'b00;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_lane_align.sv
// Combinational byte-lane steering for the data-memory responder: store lane
// placement and byte enables, load lane extraction and sign/zero extension.
module dmem_lane_align
  import dmem_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  req_type_e               req_type,
  input  logic                    sign_ext,
  input  logic [1:0]              byte_off,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH-1:0]   mem_word,
  output logic [DATA_WIDTH-1:0]   wdata_lanes,
  output logic [DATA_WIDTH/8-1:0] byte_en,
  output logic [DATA_WIDTH-1:0]   load_data,
  output logic                    err
);

  localparam int NB = DATA_WIDTH / 8;

  logic [4:0]            bit_shift;
  logic [DATA_WIDTH-1:0] shifted;

  always_comb begin
    bit_shift   = {byte_off, 3'b000};
    shifted     = mem_word >> bit_shift;
    err         = access_error(req_type, byte_off);
    wdata_lanes = wdata << bit_shift;
    byte_en     = '0;
    if (!err) begin
      byte_en = NB'((1 << access_bytes(req_type)) - 1) << byte_off;
    end
    case (req_type)
      REQ_BYTE: load_data = {{(DATA_WIDTH-8){sign_ext & shifted[7]}}, shifted[7:0]};
      REQ_HALF: load_data = {{(DATA_WIDTH-16){sign_ext & shifted[15]}}, shifted[15:0]};
      default:  load_data = mem_word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one outstanding request, byte-addressed
// little-endian storage, registered response held until the initiator takes it.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_type,
  input  logic                  req_sign_ext,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

  dmem_state_e           state;
  logic [3:0]            count;
  logic                  lat_write;
  logic                  lat_sign_ext;
  req_type_e             lat_type;
  logic [DATA_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic                  accept;
  logic                  wait_done;
  logic                  access;
  logic                  commit_store;
  logic                  cur_write;
  logic                  cur_sign_ext;
  req_type_e             cur_type;
  logic [DATA_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [AW-1:0]         word_idx;
  logic [DATA_WIDTH-1:0] al_wdata;
  logic [NB-1:0]         al_be;
  logic [DATA_WIDTH-1:0] al_load;
  logic                  al_err;
  logic                  unused_addr_bits;

  // With LATENCY = 1 the access happens on the accept edge, so the live request
  // feeds the datapath in IDLE; otherwise the latched copy does.
  assign accept       = req_valid && req_ready && (state == IDLE);
  assign wait_done    = (count <= 4'd1);
  assign cur_write    = (state == IDLE) ? req_write    : lat_write;
  assign cur_sign_ext = (state == IDLE) ? req_sign_ext : lat_sign_ext;
  assign cur_type     = (state == IDLE) ? req_type_e'(req_type) : lat_type;
  assign cur_addr     = (state == IDLE) ? req_addr     : lat_addr;
  assign cur_wdata    = (state == IDLE) ? req_wdata    : lat_wdata;
  assign word_idx     = cur_addr[AW+1:2];
  assign access       = !rst && ((accept && (LATENCY == 1)) || ((state == WAIT) && wait_done));
  assign commit_store = access && cur_write && !al_err;
  assign unused_addr_bits = ^cur_addr[DATA_WIDTH-1:AW+2];

  dmem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .req_type    (cur_type),
    .sign_ext    (cur_sign_ext),
    .byte_off    (cur_addr[1:0]),
    .wdata       (cur_wdata),
    .mem_word    (mem[word_idx]),
    .wdata_lanes (al_wdata),
    .byte_en     (al_be),
    .load_data   (al_load),
    .err         (al_err)
  );

  always_ff @(posedge clk) begin
    if (commit_store) begin
      for (int b = 0; b < NB; b++) begin
        if (al_be[b]) mem[word_idx][8*b +: 8] <= al_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      lat_write    <= 1'b0;
      lat_sign_ext <= 1'b0;
      lat_type     <= REQ_BYTE;
      lat_addr     <= '0;
      lat_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_write    <= req_write;
            lat_sign_ext <= req_sign_ext;
            lat_type     <= req_type_e'(req_type);
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
            req_ready    <= 1'b0;
            if (LATENCY == 1) begin
              state      <= RESP;
              count      <= '0;
              resp_valid <= 1'b1;
              resp_err   <= al_err;
              resp_rdata <= (cur_write || al_err) ? '0 : al_load;
            end else begin
              state <= WAIT;
              count <= COUNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (wait_done) begin
            state      <= RESP;
            count      <= '0;
            resp_valid <= 1'b1;
            resp_err   <= al_err;
            resp_rdata <= (cur_write || al_err) ? '0 : al_load;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a driver queues expected responses,
// a monitor checks data, error flag and latency at each response.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_type;
  logic        req_sign_ext;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cycle;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cycle   = 0;

  dmem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_type     (req_type),
    .req_sign_ext (req_sign_ext),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives one request, pushes its expected response on accept and optionally
  // waits for the monitor to consume it.
  task automatic applyStimulus(input logic wr, input logic [1:0] typ, input logic sx,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input bit push_exp, input bit wait_drain);
    bit accepted = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_type = typ; req_sign_ext = sx;
    req_addr = addr; req_wdata = wdata;
    for (int i = 0; i < 50 && !accepted; i++) begin
      #4;
      if (req_ready) begin
        accepted = 1;
        if (push_exp) sb_q.push_back('{rdata: exp_rdata, err: exp_err, acc_cycle: cycle});
      end
      @(negedge clk);
    end
    req_valid = 1'b0; req_write = 1'b1; req_addr = 32'hFFFF_FFFC; req_wdata = 32'hA5A5_A5A5;
    if (!accepted) begin
      n_tests++; n_fail++;
      $display("[TB] FAIL accept_timeout: addr 0x%08h never accepted", addr);
    end
    if (wait_drain) begin
      for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
      if (sb_q.size() != 0) begin
        n_tests++; n_fail++;
        $display("[TB] FAIL resp_timeout: %0d responses still pending", sb_q.size());
        sb_q.delete();
      end
    end
  endtask

  // Monitor: samples just before each rising edge.
  initial begin
    logic prev_valid = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk); #4;
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (resp_valid && !prev_valid) begin
          if (sb_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("[TB] FAIL unexpected_resp: rdata 0x%08h err %0b", resp_rdata, resp_err);
          end else begin
            checkOutput("latency", 32'(cycle - sb_q[0].acc_cycle), 32'(LAT));
          end
        end
        if (resp_valid && resp_ready && sb_q.size() != 0) begin
          e = sb_q.pop_front();
          checkOutput("resp_rdata", resp_rdata, e.rdata);
          checkOutput("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        end
        prev_valid = resp_valid;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_type = 2'b10; req_sign_ext = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    #2;
    checkOutput("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("reset_resp_rdata", resp_rdata, 32'd0);
    checkOutput("reset_resp_err", {31'b0, resp_err}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #4;
    checkOutput("reset_req_ready", {31'b0, req_ready}, 32'd1);

    // Word store / load
    applyStimulus(1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 1, 1);
    applyStimulus(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 1, 1);
    // Byte store, signed/unsigned byte loads, merged word
    applyStimulus(1, 2'b00, 0, 32'h13, 32'h0000_0080, 32'h0, 0, 1, 1);
    applyStimulus(0, 2'b00, 1, 32'h13, 32'h0, 32'hFFFF_FF80, 0, 1, 1);
    applyStimulus(0, 2'b00, 0, 32'h13, 32'h0, 32'h0000_0080, 0, 1, 1);
    applyStimulus(0, 2'b10, 0, 32'h10, 32'h0, 32'h80AD_BEEF, 0, 1, 1);
    applyStimulus(0, 2'b00, 0, 32'h11, 32'h0, 32'h0000_00BE, 0, 1, 1);
    applyStimulus(0, 2'b01, 1, 32'h12, 32'h0, 32'hFFFF_80AD, 0, 1, 1);
    // Errors: misaligned half, misaligned word store, illegal type
    applyStimulus(0, 2'b01, 0, 32'h11, 32'h0, 32'h0, 1, 1, 1);
    applyStimulus(1, 2'b10, 0, 32'h12, 32'hFFFF_FFFF, 32'h0, 1, 1, 1);
    applyStimulus(1, 2'b11, 0, 32'h10, 32'h1111_1111, 32'h0, 1, 1, 1);
    applyStimulus(0, 2'b10, 0, 32'h10, 32'h0, 32'h80AD_BEEF, 0, 1, 1);
    // Half store into upper lanes
    applyStimulus(1, 2'b01, 0, 32'h1A, 32'h5555_BEEF, 32'h0, 0, 1, 1);
    applyStimulus(0, 2'b01, 1, 32'h1A, 32'h0, 32'hFFFF_BEEF, 0, 1, 1);
    applyStimulus(0, 2'b01, 0, 32'h1A, 32'h0, 32'h0000_BEEF, 0, 1, 1);

    // Backpressure: response held while a competing request is presented
    resp_ready = 1'b0;
    applyStimulus(0, 2'b10, 0, 32'h10, 32'h0, 32'h80AD_BEEF, 0, 1, 0);
    for (int i = 0; i < 10 && !resp_valid; i++) @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_type = 2'b10; req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      #4;
      checkOutput("stall_resp_valid", {31'b0, resp_valid}, 32'd1);
      checkOutput("stall_resp_rdata", resp_rdata, 32'h80AD_BEEF);
      checkOutput("stall_resp_err", {31'b0, resp_err}, 32'd0);
      checkOutput("stall_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    applyStimulus(0, 2'b10, 0, 32'h10, 32'h0, 32'h80AD_BEEF, 0, 1, 1);

    // Reset during the wait phase of a store must drop the store
    applyStimulus(1, 2'b10, 0, 32'h20, 32'h0000_0000, 32'h0, 0, 1, 1);
    applyStimulus(1, 2'b10, 0, 32'h20, 32'h1234_5678, 32'h0, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("midrst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("midrst_resp_err", {31'b0, resp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #4;
    checkOutput("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    applyStimulus(0, 2'b10, 0, 32'h20, 32'h0, 32'h0000_0000, 0, 1, 1);

    // Address wrap-around beyond the storage depth
    applyStimulus(1, 2'b10, 0, 32'h1000, 32'hCAFE_F00D, 32'h0, 0, 1, 1);
    applyStimulus(0, 2'b10, 0, 32'h0, 32'h0, 32'hCAFE_F00D, 0, 1, 1);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
